// File: rtl/dmb_rdout_pkg.sv
// Shared types and helpers for the DMB FIFO readout path.
// State encoding, marker-bit position and a constant-foldable clog2.
package dmb_rdout_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEL,
        OE,
        RD,
        GAP
    } state_e;

    localparam int DW_DEFAULT      = 18;
    localparam int LAST_MARKER_BIT = DW_DEFAULT - 1;

    // Never returns less than 1, so a 1-entry range still gets a usable vector.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int markerPos(input int dw);
        return dw - 1;
    endfunction

endpackage

// File: rtl/prio_enc_lsb.sv
// Lowest-set-bit priority encoder: returns the index of the lowest request
// and a valid flag when any request is present.
module prio_enc_lsb #(
    parameter int N = 7,
    parameter int W = 3
) (
    input  logic [N-1:0] req_i,
    output logic [W-1:0] idx_o,
    output logic         vld_o
);

    always_comb begin
        idx_o = '0;
        vld_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = W'(i);
                vld_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_rdout_seq.sv
// Per-event FIFO readout sequencer: walks the DAV mask channel by channel,
// streams each channel's event downstream and flags stuck or runaway channels.
module fifo_rdout_seq
    import dmb_rdout_pkg::*;
#(
    parameter int NCH  = 7,
    parameter int DW   = 18,
    parameter int STMO = 40,
    parameter int MAXW = 512
) (
    input  logic                  CLKDDU,
    input  logic                  RST,
    input  logic                  START,
    input  logic [NCH-1:0]        DAVMASK,
    input  logic [NCH-1:0]        KILL,
    input  logic [NCH-1:0]        FFOR_B,
    input  logic [DW-1:0]         DATAIN,
    input  logic                  DOUT_RDY,
    output logic [NCH-1:0]        RENFIFO_B,
    output logic [NCH-1:0]        OEFIFO_B,
    output logic [DW-1:0]         DOUT,
    output logic                  DOUT_VLD,
    output logic [clog2(NCH)-1:0] DOUT_CH,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [NCH-1:0]        TMO,
    output logic [NCH-1:0]        OVF
);

    localparam int CHW  = clog2(NCH);
    localparam int TW   = clog2(STMO);
    localparam int CW   = clog2(MAXW + 1);
    localparam int LAST = markerPos(DW);

    state_e           state_q, state_d;
    logic [NCH-1:0]   pend_q, pend_d;
    logic [CHW-1:0]   ch_q, ch_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [CW-1:0]    count_q, count_d;
    logic [DW-1:0]    dout_q, dout_d;
    logic             vld_q, vld_d;
    logic [CHW-1:0]   doutCh_q, doutCh_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [NCH-1:0]   tmo_q, tmo_d;
    logic [NCH-1:0]   ovf_q, ovf_d;

    logic [CHW-1:0]   encIdx;
    logic             encVld;
    logic             rdEn;
    logic             stuck;
    logic             lastWord;
    logic             atMaxw;
    logic             timeoutHit;

    prio_enc_lsb #(
        .N(NCH),
        .W(CHW)
    ) u_prio (
        .req_i(pend_q),
        .idx_o(encIdx),
        .vld_o(encVld)
    );

    // Backpressure freezes the stall timer: only "ready downstream but no word" counts.
    assign rdEn       = (state_q == RD) && !FFOR_B[ch_q] && DOUT_RDY;
    assign stuck      = (state_q == RD) &&  FFOR_B[ch_q] && DOUT_RDY;
    assign lastWord   = DATAIN[LAST];
    assign atMaxw     = (count_q == CW'(MAXW - 1));
    assign timeoutHit = stuck && (timer_q == TW'(STMO - 1));

    always_ff @(posedge CLKDDU or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (START) state_d = SEL;
            SEL:  state_d = encVld ? OE : IDLE;
            OE:   state_d = RD;
            RD:   if ((rdEn && (lastWord || atMaxw)) || timeoutHit) state_d = GAP;
            GAP:  state_d = SEL;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        RENFIFO_B = '1;
        OEFIFO_B  = '1;
        if (state_q == OE || state_q == RD) begin
            OEFIFO_B[ch_q] = 1'b0;
        end
        if (rdEn) begin
            RENFIFO_B[ch_q] = 1'b0;
        end
    end

    always_comb begin
        pend_d   = pend_q;
        ch_d     = ch_q;
        timer_d  = timer_q;
        count_d  = count_q;
        dout_d   = dout_q;
        vld_d    = 1'b0;
        doutCh_d = doutCh_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        tmo_d    = tmo_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (START) begin
                    pend_d = DAVMASK & ~KILL;
                    tmo_d  = '0;
                    ovf_d  = '0;
                    busy_d = 1'b1;
                end
            end
            SEL: begin
                if (!encVld) begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end else begin
                    ch_d   = encIdx;
                    pend_d = pend_q & ~(NCH'(1) << encIdx);
                end
            end
            OE: begin
                timer_d = '0;
                count_d = '0;
            end
            RD: begin
                // A marker on the final permitted word is a clean end, not an overflow.
                if (rdEn) begin
                    dout_d   = DATAIN;
                    vld_d    = 1'b1;
                    doutCh_d = ch_q;
                    count_d  = count_q + CW'(1);
                    timer_d  = '0;
                    if (atMaxw && !lastWord) begin
                        ovf_d[ch_q] = 1'b1;
                    end
                end else if (stuck) begin
                    if (timeoutHit) begin
                        tmo_d[ch_q] = 1'b1;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLKDDU or posedge RST) begin
        if (RST) begin
            pend_q   <= '0;
            ch_q     <= '0;
            timer_q  <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            vld_q    <= 1'b0;
            doutCh_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            tmo_q    <= '0;
            ovf_q    <= '0;
        end else begin
            pend_q   <= pend_d;
            ch_q     <= ch_d;
            timer_q  <= timer_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            vld_q    <= vld_d;
            doutCh_q <= doutCh_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            tmo_q    <= tmo_d;
            ovf_q    <= ovf_d;
        end
    end

    assign DOUT     = dout_q;
    assign DOUT_VLD = vld_q;
    assign DOUT_CH  = doutCh_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign TMO      = tmo_q;
    assign OVF      = ovf_q;

endmodule

// File: tb/tb_fifo_rdout_seq.sv
// Self-checking bench for fifo_rdout_seq: per-channel FIFO queues feed the DUT,
// and an event-level model predicts the word stream and TMO/OVF flags.
module tb_fifo_rdout_seq;

    localparam int NCH  = 7;
    localparam int DW   = 18;
    localparam int STMO = 40;
    localparam int MAXW = 8;

    logic           CLKDDU = 1'b0;
    logic           RST = 1'b1;
    logic           START = 1'b0;
    logic [NCH-1:0] DAVMASK = '0;
    logic [NCH-1:0] KILL = '0;
    logic [NCH-1:0] FFOR_B = '1;
    logic [DW-1:0]  DATAIN = '0;
    logic           DOUT_RDY = 1'b0;
    logic [NCH-1:0] RENFIFO_B;
    logic [NCH-1:0] OEFIFO_B;
    logic [DW-1:0]  DOUT;
    logic           DOUT_VLD;
    logic [2:0]     DOUT_CH;
    logic           BUSY;
    logic           DONE;
    logic [NCH-1:0] TMO;
    logic [NCH-1:0] OVF;

    fifo_rdout_seq #(
        .NCH(NCH),
        .DW(DW),
        .STMO(STMO),
        .MAXW(MAXW)
    ) dut (
        .CLKDDU(CLKDDU),
        .RST(RST),
        .START(START),
        .DAVMASK(DAVMASK),
        .KILL(KILL),
        .FFOR_B(FFOR_B),
        .DATAIN(DATAIN),
        .DOUT_RDY(DOUT_RDY),
        .RENFIFO_B(RENFIFO_B),
        .OEFIFO_B(OEFIFO_B),
        .DOUT(DOUT),
        .DOUT_VLD(DOUT_VLD),
        .DOUT_CH(DOUT_CH),
        .BUSY(BUSY),
        .DONE(DONE),
        .TMO(TMO),
        .OVF(OVF)
    );

    always #5 CLKDDU = ~CLKDDU;

    logic [DW-1:0]  fq [NCH][$];
    logic [20:0]    sb [$];
    int             stallLeft [NCH];
    int             oeLow [NCH];
    int             checks = 0;
    int             errors = 0;
    int             cycleCnt = 0;
    int             startCyc = 0;
    int             doneCyc = 0;
    int             doneCount = 0;
    int             renLowCount = 0;
    int             rdyIdx = 0;
    int             rdyMode = 0;
    bit             stallEn = 0;
    bit             startNext = 0;
    logic [NCH-1:0] maskNext = '0;
    logic [NCH-1:0] prevOe = '1;
    logic [NCH-1:0] expTmo, expOvf;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h required 0x%0h", tag, act, exp);
        end
    endtask

    // One clock: observe registered outputs, drive the FIFO model, then retire any read.
    task automatic stepCycle();
        logic [20:0] e;
        int sel;
        @(negedge CLKDDU);
        cycleCnt++;
        if (DOUT_VLD) begin
            if (sb.size() == 0) begin
                checkOutput("dout_extra", 32'(sb.size()), 1);
            end else begin
                e = sb.pop_front();
                checkOutput("dout", {11'h0, DOUT_CH, DOUT}, {11'h0, e});
            end
        end
        if (DONE) begin
            doneCount++;
            if (doneCount == 1) doneCyc = cycleCnt;
        end
        if (OEFIFO_B != prevOe && prevOe != '1) begin
            checkOutput("gap", 32'(OEFIFO_B), 32'h7f);
        end
        prevOe = OEFIFO_B;
        checkOutput("oe_onehot", 32'($countones(~OEFIFO_B) <= 1), 1);
        sel = -1;
        for (int c = 0; c < NCH; c++) begin
            if (!OEFIFO_B[c]) begin
                oeLow[c]++;
                sel = c;
            end
            if (stallLeft[c] > 0) stallLeft[c]--;
            else if (stallEn && $urandom_range(0, 5) == 0) stallLeft[c] = $urandom_range(1, 4);
            FFOR_B[c] = (fq[c].size() == 0) || (stallLeft[c] > 0);
        end
        DATAIN = (sel >= 0 && fq[sel].size() > 0) ? fq[sel][0] : DW'($urandom);
        rdyIdx++;
        case (rdyMode)
            1: DOUT_RDY = ($urandom_range(0, 3) != 0);
            2: DOUT_RDY = ((rdyIdx % 4) == 0) || ((rdyIdx % 4) == 3);
            default: DOUT_RDY = 1'b1;
        endcase
        START = startNext;
        if (startNext) begin
            DAVMASK  = maskNext;
            startCyc = cycleCnt;
        end
        startNext = 0;
        #1;
        if (RENFIFO_B != '1) begin
            checkOutput("ren_rdy", 32'(DOUT_RDY), 1);
            checkOutput("ren_oe", 32'(RENFIFO_B), 32'(OEFIFO_B));
            checkOutput("ren_ffor", 32'(~RENFIFO_B & FFOR_B), 0);
            for (int c = 0; c < NCH; c++) begin
                if (!RENFIFO_B[c] && fq[c].size() > 0) begin
                    void'(fq[c].pop_front());
                    renLowCount++;
                end
            end
        end
    endtask

    task automatic fillWords(input int c, input int len, input bit withMarker);
        for (int i = 0; i < len; i++) begin
            fq[c].push_back({(withMarker && i == len - 1), 17'($urandom)});
        end
    endtask

    task automatic flushAll();
        for (int c = 0; c < NCH; c++) begin
            fq[c].delete();
            stallLeft[c] = 0;
        end
        sb.delete();
    endtask

    // Event-level model: each live channel yields words up to its marker, capped at MAXW.
    task automatic buildExpect(input logic [NCH-1:0] mask);
        int n;
        bit ended;
        expTmo = '0;
        expOvf = '0;
        for (int c = 0; c < NCH; c++) begin
            if (mask[c] && !KILL[c]) begin
                n = 0;
                ended = 0;
                for (int i = 0; i < fq[c].size() && !ended; i++) begin
                    sb.push_back({3'(c), fq[c][i]});
                    n++;
                    if (fq[c][i][DW-1]) ended = 1;
                    else if (n == MAXW) begin
                        expOvf[c] = 1'b1;
                        ended = 1;
                    end
                end
                if (!ended) expTmo[c] = 1'b1;
            end
        end
    endtask

    task automatic applyStimulus(input logic [NCH-1:0] mask, input int restartAt);
        int n;
        buildExpect(mask);
        doneCount   = 0;
        renLowCount = 0;
        for (int c = 0; c < NCH; c++) oeLow[c] = 0;
        startNext = 1;
        maskNext  = mask;
        n = 0;
        while (doneCount == 0 && n < 3000) begin
            if (n == restartAt) begin
                startNext = 1;
                maskNext  = '1;
            end
            stepCycle();
            n++;
        end
        checkOutput("event_done", 32'(doneCount > 0), 1);
        checkOutput("tmo", 32'(TMO), 32'(expTmo));
        checkOutput("ovf", 32'(OVF), 32'(expOvf));
        checkOutput("sb_left", 32'(sb.size()), 0);
        checkOutput("busy_end", 32'(BUSY), 0);
        repeat (3) stepCycle();
        checkOutput("done_once", 32'(doneCount), 1);
    endtask

    initial begin
        int n;
        logic [NCH-1:0] mask;
        for (int c = 0; c < NCH; c++) begin
            stallLeft[c] = 0;
            oeLow[c] = 0;
        end
        repeat (3) stepCycle();
        checkOutput("rst_ren", 32'(RENFIFO_B), 32'h7f);
        checkOutput("rst_oe", 32'(OEFIFO_B), 32'h7f);
        checkOutput("rst_dout", 32'(DOUT), 0);
        checkOutput("rst_vld", 32'(DOUT_VLD), 0);
        checkOutput("rst_ch", 32'(DOUT_CH), 0);
        checkOutput("rst_busy", 32'(BUSY), 0);
        checkOutput("rst_done", 32'(DONE), 0);
        checkOutput("rst_tmo", 32'(TMO), 0);
        checkOutput("rst_ovf", 32'(OVF), 0);
        RST = 1'b0;
        repeat (2) stepCycle();

        fillWords(2, 4, 1);
        fillWords(4, 4, 1);
        fillWords(6, 4, 1);
        applyStimulus(7'b1010100, -1);
        checkOutput("three_ch_reads", 32'(renLowCount), 12);
        flushAll();

        applyStimulus(7'b0000010, -1);
        checkOutput("tmo_oe_cycles", 32'(oeLow[1]), 32'(STMO + 1));
        checkOutput("tmo_no_read", 32'(renLowCount), 0);

        fillWords(0, 20, 0);
        applyStimulus(7'b0000001, -1);
        checkOutput("maxw_reads", 32'(renLowCount), 8);
        checkOutput("maxw_left", 32'(fq[0].size()), 12);
        checkOutput("maxw_ren_hi", 32'(RENFIFO_B[0]), 1);
        flushAll();

        rdyMode = 2;
        fillWords(3, 6, 1);
        applyStimulus(7'b0001000, -1);
        checkOutput("bp_reads", 32'(renLowCount), 6);
        rdyMode = 0;
        flushAll();

        KILL = 7'b0000100;
        fillWords(0, 3, 1);
        fillWords(1, 3, 1);
        fillWords(2, 3, 1);
        applyStimulus(7'b0000101, 3);
        checkOutput("kill_ch2_left", 32'(fq[2].size()), 3);
        checkOutput("busy_start_ch1_left", 32'(fq[1].size()), 3);
        KILL = '0;
        flushAll();

        applyStimulus('0, -1);
        checkOutput("empty_latency", 32'(doneCyc - startCyc), 2);

        stallEn = 1;
        for (int ev = 0; ev < 20; ev++) begin
            flushAll();
            KILL    = NCH'($urandom) & NCH'($urandom);
            mask    = NCH'($urandom);
            rdyMode = $urandom_range(0, 1);
            for (int c = 0; c < NCH; c++) begin
                case ($urandom_range(0, 5))
                    3:       fillWords(c, $urandom_range(MAXW + 1, MAXW + 4), 0);
                    4:       ;
                    5:       fillWords(c, $urandom_range(1, 3), 0);
                    default: fillWords(c, $urandom_range(1, MAXW), 1);
                endcase
            end
            applyStimulus(mask, -1);
        end
        stallEn = 0;
        rdyMode = 0;
        KILL    = '0;
        flushAll();

        fillWords(5, 10, 1);
        buildExpect(7'b0100000);
        startNext = 1;
        maskNext  = 7'b0100000;
        n = 0;
        while (sb.size() > 7 && n < 50) begin
            stepCycle();
            n++;
        end
        checkOutput("rst_mid_reached", 32'(sb.size() <= 7), 1);
        RST = 1'b1;
        #1;
        checkOutput("rst_mid_ren", 32'(RENFIFO_B), 32'h7f);
        checkOutput("rst_mid_oe", 32'(OEFIFO_B), 32'h7f);
        checkOutput("rst_mid_busy", 32'(BUSY), 0);
        checkOutput("rst_mid_vld", 32'(DOUT_VLD), 0);
        flushAll();
        repeat (2) stepCycle();
        RST = 1'b0;
        renLowCount = 0;
        repeat (3) stepCycle();
        checkOutput("post_rst_ren", 32'(renLowCount), 0);
        checkOutput("post_rst_busy", 32'(BUSY), 0);
        fillWords(5, 5, 1);
        applyStimulus(7'b0100000, -1);
        checkOutput("post_rst_reads", 32'(renLowCount), 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_rdout_seq.md
Name: fifo_rdout_seq

Overview:
- Parametrised per-event FIFO readout sequencer for the DMB control path. Generalises the fixed 7-channel DCFEB/TMB/ALCT readout to NCH channels of DW-bit words.
- On START, takes a per-event DAV mask and visits each flagged channel in ascending index order. For each one it drives the active-low output-enable and read-enable, streams words downstream with a ready handshake, and detects the end-of-event marker.
- Adds a stuck-channel timeout, a runaway word limit and per-channel kill. Sits between the DAV/L1A bookkeeping and the output formatter.

Parameters:
- NCH, 7, number of FIFO channels (2..16).
- DW, 18, FIFO word width; bit DW-1 is the last-word-of-event marker.
- STMO, 40, cycles a selected channel may sit not-ready before it is abandoned (>=2).
- MAXW, 512, maximum words read from one channel per event.

Ports:
- CLKDDU  in  1  readout clock.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  one-cycle pulse; samples DAVMASK. Accepted only when BUSY=0.
- DAVMASK  in  NCH  channels holding data for this event.
- KILL  in  NCH  channels excluded from readout (static).
- FFOR_B  in  NCH  active-low per-channel "word available".
- DATAIN  in  DW  shared FIFO data bus; first-word-fall-through, valid while OEFIFO_B[ch]=0.
- DOUT_RDY  in  1  downstream ready.
- RENFIFO_B  out  NCH  active-low read enable; one-hot-low or all ones.
- OEFIFO_B  out  NCH  active-low output enable; one-hot-low or all ones.
- DOUT  out  DW  registered data word.
- DOUT_VLD  out  1  DOUT valid this cycle.
- DOUT_CH  out  clog2(NCH)  source channel of DOUT.
- BUSY  out  1  event in progress.
- DONE  out  1  one-cycle pulse at end of event.
- TMO  out  NCH  channels that timed out this event; held until next START.
- OVF  out  NCH  channels that hit MAXW this event; held until next START.

Behaviour:
- Reset values: RENFIFO_B and OEFIFO_B all ones; DOUT=0; DOUT_VLD=0; DOUT_CH=0; BUSY=0; DONE=0; TMO=0; OVF=0; state IDLE.
- Reset mid-event aborts immediately. No FIFO read is issued on the cycle RST deasserts.
- IDLE:
  - On START: pend <= DAVMASK & ~KILL; TMO, OVF <= 0; BUSY <= 1; go to SEL.
  - START while BUSY=1 is ignored.
- SEL:
  - If pend=0: DONE=1 for one cycle, BUSY <= 0, go to IDLE. An empty mask therefore gives DONE two cycles after START.
  - Otherwise ch <= lowest set bit of pend; clear that bit; go to OE.
- OE (one cycle): OEFIFO_B[ch]=0 for bus settling; no read; timer <= 0; word count <= 0. Go to RD.
- RD:
  - OEFIFO_B[ch]=0.
  - RENFIFO_B[ch] = !(FFOR_B[ch]==0 && DOUT_RDY). This is combinational from registered state and inputs.
  - On a read cycle: DOUT <= DATAIN; DOUT_VLD <= 1; DOUT_CH <= ch; count++; timer <= 0.
  - If the consumed word has DATAIN[DW-1]=1, or count reaches MAXW, go to GAP. At MAXW, also set OVF[ch].
  - On a non-read cycle: DOUT_VLD <= 0.
  - If FFOR_B[ch]=1, timer++. At timer==STMO-1, set TMO[ch] and go to GAP.
  - DOUT_RDY=0 freezes the timer (backpressure is not a stall).
- GAP (one cycle): all enables high, preventing bus overlap between channels. Go to SEL.
- Latency: first DOUT_VLD appears 3 cycles after START, assuming ch ready and DOUT_RDY=1.
- Throughput: 1 word/cycle within a channel; 3 overhead cycles per channel.
- Simultaneous conditions:
  - Last-word marker on the MAXW-th word: exit as a normal end; OVF not set.
  - KILL and DAVMASK both set for a channel: the channel is skipped with no flag.
  - FFOR_B on a non-selected channel is ignored.
- DOUT holds its last value when DOUT_VLD=0.

Decomposition:
- Shared package `dmb_rdout_pkg`: state enum (IDLE, SEL, OE, RD, GAP); last-marker bit-position constant; clog2 function.
- One natural sub-module, `prio_enc_lsb`: parametrised lowest-set-bit encoder returning index and valid.

Test Plan:
- NCH=7, DAVMASK=7'b1010100; ch2, ch4, ch6 each with 4 words (last word bit17=1), DOUT_RDY=1.
  - Required: 12 DOUT_VLD words in order ch2, ch4, ch6.
  - One all-ones enable cycle between channels.
  - DONE exactly once; TMO=0, OVF=0.
- DAVMASK=7'b0000010; ch1 FFOR_B held high.
  - Required: after 40 cycles in RD, TMO=7'b0000010.
  - No RENFIFO_B low; DONE follows.
- DAVMASK=7'b0000001, MAXW=8, 20 words with no marker.
  - Required: exactly 8 words read; OVF[0]=1; RENFIFO_B[0] high afterwards.
- DOUT_RDY toggled 1,0,0,1 during a 6-word read.
  - Required: RENFIFO_B low only when DOUT_RDY=1.
  - All 6 words delivered in order; no timeout for any stall length.
- KILL=7'b0000100, DAVMASK=7'b0000101.
  - Required: only ch0 read.
  - START during BUSY ignored.
  - Empty mask gives DONE 2 cycles after START.
- RST asserted while in RD mid-channel.
  - Required: all enables high, BUSY=0, DOUT_VLD=0 in the same cycle.
  - A subsequent START reads normally.
